// File: rtl/alu_arbiter_pkg.sv
// Shared definitions for the ALU arbiter: op-code constants and the FSM state encoding.
package alu_arbiter_pkg;

  localparam logic [2:0] OP_ROL = 3'b000;
  localparam logic [2:0] OP_SLL = 3'b001;
  localparam logic [2:0] OP_ROR = 3'b010;
  localparam logic [2:0] OP_SRA = 3'b011;
  localparam logic [2:0] OP_ADD = 3'b100;
  localparam logic [2:0] OP_SUB = 3'b101;
  localparam logic [2:0] OP_OR  = 3'b110;
  localparam logic [2:0] OP_AND = 3'b111;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_RESP = 2'd2
  } arb_state_e;

endpackage

// File: rtl/alu_arb_pick.sv
// Combinational two-way grant selector. A lone valid wins outright; on a tie
// the requester that was not granted last (ptr) wins.
module alu_arb_pick (
  input  logic [1:0] valid,
  input  logic       ptr,
  output logic       gnt_any,
  output logic       gnt_id
);

  assign gnt_any = |valid;
  assign gnt_id  = (&valid) ? ~ptr : valid[1];

endmodule

// File: rtl/alu_arbiter.sv
// Two-requester front end for a shared external ALU.
// Flow: accept (IDLE, or RESP being drained) -> EXEC (drive ALU) -> RESP (hold result).
// Optional feature: define ALU_ARB_RR_EN for round-robin tie-breaking; otherwise
// requester 0 always wins a tie and no grant pointer is kept.
module alu_arbiter
  import alu_arbiter_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req0_valid,
  output logic             req0_ready,
  input  logic [2:0]       req0_op,
  input  logic [WIDTH-1:0] req0_a,
  input  logic [WIDTH-1:0] req0_b,
  input  logic             req1_valid,
  output logic             req1_ready,
  input  logic [2:0]       req1_op,
  input  logic [WIDTH-1:0] req1_a,
  input  logic [WIDTH-1:0] req1_b,
  output logic [2:0]       alu_op,
  output logic [WIDTH-1:0] alu_a,
  output logic [WIDTH-1:0] alu_b,
  input  logic [WIDTH-1:0] alu_out,
  input  logic             alu_err,
  output logic             rsp_valid,
  output logic             rsp_id,
  output logic [WIDTH-1:0] rsp_data,
  output logic             rsp_err,
  input  logic             rsp_ready
);

  arb_state_e       state;
  logic             ptr, gnt_any, gnt_id, accept, id_q;
  logic [2:0]       sel_op;
  logic [WIDTH-1:0] sel_a, sel_b;

`ifdef ALU_ARB_RR_EN
  logic last_gnt;

  // Remember who won the most recent acceptance; reset favours requester 0 next.
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n)      last_gnt <= 1'b1;
    else if (accept) last_gnt <= gnt_id;

  assign ptr = last_gnt;
`else
  // Pretend requester 1 always won last, so a tie resolves to requester 0.
  assign ptr = 1'b1;
`endif

  alu_arb_pick u_pick (
    .valid   ({req1_valid, req0_valid}),
    .ptr     (ptr),
    .gnt_any (gnt_any),
    .gnt_id  (gnt_id)
  );

  // rst_n gates acceptance so no ready escapes while reset is held.
  assign accept     = rst_n && gnt_any &&
                      ((state == ST_IDLE) || ((state == ST_RESP) && rsp_ready));
  assign req0_ready = accept && !gnt_id;
  assign req1_ready = accept &&  gnt_id;

  assign sel_op = gnt_id ? req1_op : req0_op;
  assign sel_a  = gnt_id ? req1_a  : req0_a;
  assign sel_b  = gnt_id ? req1_b  : req0_b;

  // Main FSM; the alu_* outputs double as the operand registers and only change on acceptance.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= ST_IDLE;
      id_q      <= 1'b0;
      alu_op    <= '0;
      alu_a     <= '0;
      alu_b     <= '0;
      rsp_valid <= 1'b0;
      rsp_id    <= 1'b0;
      rsp_data  <= '0;
      rsp_err   <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (accept) begin
            alu_op <= sel_op;
            alu_a  <= sel_a;
            alu_b  <= sel_b;
            id_q   <= gnt_id;
            state  <= ST_EXEC;
          end
        end
        ST_EXEC: begin
          rsp_valid <= 1'b1;
          rsp_id    <= id_q;
          rsp_data  <= alu_out;
          rsp_err   <= alu_err;
          state     <= ST_RESP;
        end
        ST_RESP: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            if (accept) begin
              alu_op <= sel_op;
              alu_a  <= sel_a;
              alu_b  <= sel_b;
              id_q   <= gnt_id;
              state  <= ST_EXEC;
            end else begin
              state  <= ST_IDLE;
            end
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_arbiter.sv
// Directed bench for alu_arbiter: a vector table through a behavioural ALU,
// plus hand-written tie, stall and mid-EXEC reset sequences.
module tb_alu_arbiter;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req0_valid, req1_valid, req0_ready, req1_ready;
  logic [2:0]  req0_op, req1_op, alu_op;
  logic [15:0] req0_a, req0_b, req1_a, req1_b, alu_a, alu_b, alu_out, rsp_data;
  logic        alu_err, rsp_valid, rsp_id, rsp_err, rsp_ready;

  int pass_cnt = 0;
  int total    = 0;

  always #5 clk = ~clk;

  alu_arbiter #(.WIDTH(16)) dut (
    .clk(clk), .rst_n(rst_n),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_op(req0_op), .req0_a(req0_a), .req0_b(req0_b),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_op(req1_op), .req1_a(req1_a), .req1_b(req1_b),
    .alu_op(alu_op), .alu_a(alu_a), .alu_b(alu_b), .alu_out(alu_out), .alu_err(alu_err),
    .rsp_valid(rsp_valid), .rsp_id(rsp_id), .rsp_data(rsp_data), .rsp_err(rsp_err), .rsp_ready(rsp_ready)
  );

  // Behavioural model of the external ALU.
  logic [3:0] sh;
  logic [4:0] rsh;
  always_comb begin
    alu_out = '0;
    sh      = alu_b[3:0];
    rsh     = 5'd16 - {1'b0, sh};
    case (alu_op)
      3'b100: alu_out = alu_a + alu_b;
      3'b101: alu_out = alu_a - alu_b;
      3'b110: alu_out = alu_a | alu_b;
      3'b111: alu_out = alu_a & alu_b;
      3'b001: alu_out = alu_a << sh;
      3'b000: alu_out = (alu_a << sh) | (alu_a >> rsh);
      3'b010: alu_out = (alu_a >> sh) | (alu_a << rsh);
      3'b011: alu_out = $signed(alu_a) >>> sh;
      default: alu_out = '0;
    endcase
  end

  typedef struct {
    logic        id;
    logic [2:0]  op;
    logic [15:0] a, b;
    logic        err;
    logic [15:0] exp;
  } vec_t;

  vec_t vt[10];
  int   grants[$];
  int   exp_g[4];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  task automatic drive(input logic id, input logic [2:0] op, input logic [15:0] a, input logic [15:0] b);
    if (id) begin
      req1_valid = 1'b1; req1_op = op; req1_a = a; req1_b = b;
    end else begin
      req0_valid = 1'b1; req0_op = op; req0_a = a; req0_b = b;
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    vt[0] = '{1'b0, 3'b100, 16'h0003, 16'h0004, 1'b0, 16'h0007};
    vt[1] = '{1'b1, 3'b101, 16'h0010, 16'h0001, 1'b0, 16'h000F};
    vt[2] = '{1'b0, 3'b101, 16'h0000, 16'h0001, 1'b1, 16'hFFFF};
    vt[3] = '{1'b1, 3'b110, 16'hF0F0, 16'h0F0F, 1'b0, 16'hFFFF};
    vt[4] = '{1'b0, 3'b111, 16'hF0F0, 16'h3C3C, 1'b0, 16'h3030};
    vt[5] = '{1'b1, 3'b001, 16'h0001, 16'h0004, 1'b0, 16'h0010};
    vt[6] = '{1'b0, 3'b000, 16'h8001, 16'h0001, 1'b0, 16'h0003};
    vt[7] = '{1'b1, 3'b010, 16'h0001, 16'h0001, 1'b0, 16'h8000};
    vt[8] = '{1'b0, 3'b011, 16'h8000, 16'h0003, 1'b0, 16'hF000};
    vt[9] = '{1'b1, 3'b100, 16'hFFFF, 16'h0001, 1'b0, 16'h0000};
`ifdef ALU_ARB_RR_EN
    exp_g = '{0, 1, 0, 1};
`else
    exp_g = '{0, 0, 0, 0};
`endif

    // Reset state, with both requesters pushing.
    rst_n = 1'b0; rsp_ready = 1'b0; alu_err = 1'b0;
    req0_valid = 1'b1; req1_valid = 1'b1;
    req0_op = '0; req0_a = '0; req0_b = '0; req1_op = '0; req1_a = '0; req1_b = '0;
    #3;
    chk("rst_ready0", req0_ready, 0);
    chk("rst_ready1", req1_ready, 0);
    chk("rst_rsp_valid", rsp_valid, 0);
    chk("rst_rsp_id", rsp_id, 0);
    chk("rst_rsp_err", rsp_err, 0);
    chk("rst_rsp_data", rsp_data, 0);
    chk("rst_alu_op", alu_op, 0);
    chk("rst_alu_ab", {alu_a, alu_b}, 0);
    req0_valid = 1'b0; req1_valid = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;

    // Table: one operation per vector, single requester.
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      drive(vt[i].id, vt[i].op, vt[i].a, vt[i].b);
      #1;
      chk($sformatf("v%0d_ready", i), {req1_ready, req0_ready}, vt[i].id ? 2'b10 : 2'b01);
      @(negedge clk);
      req0_valid = 1'b0; req1_valid = 1'b0; alu_err = vt[i].err;
      #1;
      chk($sformatf("v%0d_alu_op", i), alu_op, vt[i].op);
      chk($sformatf("v%0d_alu_ab", i), {alu_a, alu_b}, {vt[i].a, vt[i].b});
      chk($sformatf("v%0d_exec_nvalid", i), rsp_valid, 0);
      @(negedge clk);
      alu_err = 1'b0;
      #1;
      chk($sformatf("v%0d_rsp_valid", i), rsp_valid, 1);
      chk($sformatf("v%0d_rsp_id", i), rsp_id, vt[i].id);
      chk($sformatf("v%0d_rsp_data", i), rsp_data, vt[i].exp);
      chk($sformatf("v%0d_rsp_err", i), rsp_err, vt[i].err);
      rsp_ready = 1'b1;
      @(negedge clk);
      rsp_ready = 1'b0;
      #1;
      chk($sformatf("v%0d_idle_nvalid", i), rsp_valid, 0);
      chk($sformatf("v%0d_alu_hold", i), alu_op, vt[i].op);
    end

    // Stall in RESP for 5 cycles with req1 waiting, then same-cycle handoff.
    @(negedge clk);
    drive(1'b0, 3'b101, 16'h0009, 16'h0002);
    #1;
    chk("stall_acc0", req0_ready, 1);
    @(negedge clk);
    req0_valid = 1'b0;
    drive(1'b1, 3'b111, 16'hFFFF, 16'h00FF);
    #1;
    chk("stall_exec_noready", req1_ready, 0);
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      #1;
      chk($sformatf("stall%0d_valid", k), rsp_valid, 1);
      chk($sformatf("stall%0d_data_id", k), {rsp_id, rsp_data}, {1'b0, 16'h0007});
      chk($sformatf("stall%0d_noready", k), {req1_ready, req0_ready}, 2'b00);
    end
    @(negedge clk);
    rsp_ready = 1'b1;
    #1;
    chk("stall_release_ready1", {req1_ready, req0_ready}, 2'b10);
    @(negedge clk);
    req1_valid = 1'b0; rsp_ready = 1'b0;
    #1;
    chk("stall_next_alu_op", alu_op, 3'b111);
    @(negedge clk);
    #1;
    chk("stall_next_rsp", {rsp_valid, rsp_id, rsp_data}, {1'b1, 1'b1, 16'h00FF});
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;

    // Reset during EXEC discards the operation.
    @(negedge clk);
    drive(1'b1, 3'b100, 16'h0001, 16'h0001);
    #1;
    chk("mid_acc1", req1_ready, 1);
    @(negedge clk);
    req1_valid = 1'b0;
    #1;
    chk("mid_exec_op", alu_op, 3'b100);
    #2;
    rst_n = 1'b0; req0_valid = 1'b1;
    #1;
    chk("mid_rst_rsp_valid", rsp_valid, 0);
    chk("mid_rst_alu_op", alu_op, 0);
    chk("mid_rst_ready0", req0_ready, 0);
    @(negedge clk);
    rst_n = 1'b1; req0_valid = 1'b0;
    @(negedge clk);
    #1;
    chk("mid_no_rsp", rsp_valid, 0);
    @(negedge clk);
    drive(1'b0, 3'b110, 16'h0000, 16'h0000);
    drive(1'b1, 3'b110, 16'h0000, 16'h0000);
    #1;
    chk("mid_first_grant", {req1_ready, req0_ready}, 2'b01);
    @(negedge clk);
    req0_valid = 1'b0; req1_valid = 1'b0;
    @(negedge clk);
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;

    // Tie: both valid every cycle with rsp_ready held high.
    do_reset();
    drive(1'b0, 3'b100, 16'h0001, 16'h0002);
    drive(1'b1, 3'b100, 16'h0003, 16'h0004);
    rsp_ready = 1'b1;
    for (int c = 0; c < 8; c++) begin
      #1;
      if (req0_ready && req1_ready) chk("tie_both_ready", 1, 0);
      if (req0_ready) grants.push_back(0);
      if (req1_ready) grants.push_back(1);
      @(negedge clk);
    end
    req0_valid = 1'b0; req1_valid = 1'b0;
    @(negedge clk);
    rsp_ready = 1'b0;
    chk("tie_grant_count", grants.size(), 4);
    for (int g = 0; g < 4 && g < grants.size(); g++)
      chk($sformatf("tie_grant%0d", g), grants[g], exp_g[g]);

    $display("%0d/%0d checks passed", pass_cnt, total);
    $finish;
  end

endmodule
